dcache_controller: RTL and testbench
====================================

// Module: dcache_controller
// PURPOSE
//  Control FSM for dcache_datapath (direct-mapped, write-back, write-allocate L1 D-cache).
//  Accepts one pipeline request at a time, resolves hit/miss from datapath status, and
//  sequences dirty-line writeback and line refill word-by-word over the L2 interface.
//  Sits between the pipeline/L2 handshakes and the datapath control strobes.
// PARAMETERS
//  LINE_SIZE   32    bytes per line; sets refill length (LINE_SIZE/4 words); must be >= 8
//  CACHE_SIZE  1024  bytes; elaboration checks only
//  XLEN        32    word width; elaboration-time $error if not 32
// PORTS
//  clk                                input   1  clock
//  reset                              input   1  synchronous, active-high
//  pipe_req_valid                     input   1  request held stable until fulfilled
//  pipe_req_type                      input   memory_operation_e  LOAD/STORE/CLFLUSH
//  pipe_req_fulfilled                 output  1  one-cycle pulse; load data valid same cycle
//  l2_req_valid                       output  1  L2 word request (address from datapath)
//  l2_req_type                        output  memory_operation_e  LOAD (refill) / STORE (writeback)
//  l2_req_fulfilled                   input   1  L2 completed current word this cycle
//  valid_block_match, valid_dirty_bit input   1  datapath status for pipe_req_address set
//  counter_done                       input   1  datapath word counter == 0
//  flush_mode, load_mode              output  1  datapath steering (word = counter)
//  perform_write                      output  1  datapath data array write strobe
//  set_selected_dirty_bit, clear_selected_dirty_bit  output 1  dirty bit control
//  clear_selected_valid_bit, finish_new_line_install output 1  valid/tag control
//  set_new_l2_block_address, use_dirty_tag_for_l2_block_address output 1  L2 addr latch
//  reset_counter, decrement_counter   output  1  datapath word counter (resets to all-ones)
// BEHAVIOUR
//  - States: IDLE, WRITEBACK, REFILL. Reset -> IDLE; every output 0 in reset cycle.
//  - All outputs are Moore/Mealy combinational on state+inputs; default 0; no output registered.
//  - IDLE, no valid: all outputs 0.
//  - IDLE, LOAD hit (valid_block_match=1): pipe_req_fulfilled=1 same cycle (0-cycle latency).
//  - IDLE, STORE hit: perform_write=1, set_selected_dirty_bit=1, pipe_req_fulfilled=1.
//  - IDLE, CLFLUSH, not (valid & dirty) for matching line: clear_selected_valid_bit iff
//    valid_block_match; pipe_req_fulfilled=1.
//  - IDLE, miss (or CLFLUSH hit) with valid_dirty_bit=1: set_new_l2_block_address=1,
//    use_dirty_tag_for_l2_block_address=1, reset_counter=1 -> WRITEBACK.
//  - IDLE, LOAD/STORE miss with valid_dirty_bit=0: set_new_l2_block_address=1 (dirty tag 0),
//    reset_counter=1, clear_selected_valid_bit=1 -> REFILL.
//  - WRITEBACK: flush_mode=1, l2_req_valid=1, l2_req_type=STORE. Words issued highest first.
//    On l2_req_fulfilled & !counter_done: decrement_counter. On l2_req_fulfilled & counter_done:
//    clear_selected_dirty_bit=1; CLFLUSH -> clear_selected_valid_bit, pipe_req_fulfilled, IDLE;
//    else set_new_l2_block_address (own tag), reset_counter, clear_selected_valid_bit -> REFILL.
//  - REFILL: load_mode=1, l2_req_valid=1, l2_req_type=LOAD. On l2_req_fulfilled:
//    perform_write=1; !counter_done: decrement_counter; counter_done: finish_new_line_install=1,
//    -> IDLE. Request then re-resolves as a hit next cycle (miss latency = 1 + N words + 1).
//  - l2_req_fulfilled ignored in IDLE. Line valid bit is 0 throughout REFILL, so no false hit.
//  - Request must not change while pending; change mid-miss is a protocol violation (assert).
//  - reset mid-WRITEBACK/REFILL: -> IDLE next edge, outputs 0; datapath clears valid array.
//  - L2 stalls (l2_req_fulfilled=0) hold state and all strobes except l2_req_valid at 0.
// STRUCTURE
//  - torrence_types: memory_operation_e (existing), new dcache_state_e {IDLE,WRITEBACK,REFILL}.
//  - Single module; one always_ff state register, one always_comb next-state/output block.
//  - Top-level dcache wrapper instantiates dcache_controller + dcache_datapath.
// TESTING (LINE_SIZE=32, 8 words; bench = controller+datapath+L2 model, random stall 0-3 cyc)
//  - Cold LOAD 0x0000_0040 -> 8 L2 LOADs to 0x5C..0x40, finish_install, fulfilled on cycle 10.
//  - STORE hit 0x44 data 0xDEADBEEF -> fulfilled same cycle; later LOAD 0x44 returns DEADBEEF.
//  - LOAD 0x0000_0444 (same set, dirty) -> 8 L2 STOREs to 0x5C..0x40 with old data, then refill.
//  - CLFLUSH dirty 0x44 -> 8 writeback words, valid & dirty cleared; CLFLUSH miss -> 0-cycle ack.
//  - reset asserted on 4th REFILL word -> IDLE, no l2_req_valid, next LOAD misses fresh.
//  - L2 stalls 3 cycles per word -> counter/perform_write only on fulfilled cycles; SVA checks.

Source files
------------

// File: rtl/dcache_controller_pkg.sv
// rtl/dcache_controller_pkg.sv - shared types for the L1 data cache control path
package dcache_controller_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    STORE   = 2'd1,
    CLFLUSH = 2'd2
  } memory_operation_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } dcache_state_e;

endpackage

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - hit/miss resolution, dirty-line writeback and line refill sequencing
// for a direct-mapped write-back write-allocate L1 data cache.
module dcache_controller
  import dcache_controller_pkg::*;
#(
  parameter int LINE_SIZE  = 32,
  parameter int CACHE_SIZE = 1024,
  parameter int XLEN       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_req_valid,
  input  memory_operation_e pipe_req_type,
  output logic              pipe_req_fulfilled,
  output logic              l2_req_valid,
  output memory_operation_e l2_req_type,
  input  logic              l2_req_fulfilled,
  input  logic              valid_block_match,
  input  logic              valid_dirty_bit,
  input  logic              counter_done,
  output logic              flush_mode,
  output logic              load_mode,
  output logic              perform_write,
  output logic              set_selected_dirty_bit,
  output logic              clear_selected_dirty_bit,
  output logic              clear_selected_valid_bit,
  output logic              finish_new_line_install,
  output logic              set_new_l2_block_address,
  output logic              use_dirty_tag_for_l2_block_address,
  output logic              reset_counter,
  output logic              decrement_counter
);

  if (XLEN != 32) begin : g_xlen_check
    $error("dcache_controller: XLEN must be 32");
  end
  if (LINE_SIZE < 8 || (LINE_SIZE & (LINE_SIZE - 1)) != 0) begin : g_line_check
    $error("dcache_controller: LINE_SIZE must be a power of two >= 8");
  end
  if (CACHE_SIZE < LINE_SIZE || (CACHE_SIZE % LINE_SIZE) != 0) begin : g_size_check
    $error("dcache_controller: CACHE_SIZE must be a multiple of LINE_SIZE");
  end

  dcache_state_e state;
  dcache_state_e state_next;
  logic          start_miss;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next                         = state;
    start_miss                         = 1'b0;
    pipe_req_fulfilled                 = 1'b0;
    l2_req_valid                       = 1'b0;
    l2_req_type                        = LOAD;
    flush_mode                         = 1'b0;
    load_mode                          = 1'b0;
    perform_write                      = 1'b0;
    set_selected_dirty_bit             = 1'b0;
    clear_selected_dirty_bit           = 1'b0;
    clear_selected_valid_bit           = 1'b0;
    finish_new_line_install            = 1'b0;
    set_new_l2_block_address           = 1'b0;
    use_dirty_tag_for_l2_block_address = 1'b0;
    reset_counter                      = 1'b0;
    decrement_counter                  = 1'b0;

    // Outputs are forced quiet during the reset cycle whatever the current state.
    if (!reset) begin
      case (state)
        IDLE: begin
          if (pipe_req_valid) begin
            case (pipe_req_type)
              LOAD: begin
                if (valid_block_match) pipe_req_fulfilled = 1'b1;
                else start_miss = 1'b1;
              end
              STORE: begin
                if (valid_block_match) begin
                  perform_write          = 1'b1;
                  set_selected_dirty_bit = 1'b1;
                  pipe_req_fulfilled     = 1'b1;
                end else begin
                  start_miss = 1'b1;
                end
              end
              CLFLUSH: begin
                if (valid_block_match && valid_dirty_bit) begin
                  start_miss = 1'b1;
                end else begin
                  clear_selected_valid_bit = valid_block_match;
                  pipe_req_fulfilled       = 1'b1;
                end
              end
              default: ;
            endcase
          end

          // A dirty victim is written back under its own tag before any refill.
          if (start_miss) begin
            set_new_l2_block_address = 1'b1;
            reset_counter            = 1'b1;
            if (valid_dirty_bit) begin
              use_dirty_tag_for_l2_block_address = 1'b1;
              state_next                         = WRITEBACK;
            end else begin
              clear_selected_valid_bit = 1'b1;
              state_next               = REFILL;
            end
          end
        end

        WRITEBACK: begin
          flush_mode   = 1'b1;
          l2_req_valid = 1'b1;
          l2_req_type  = STORE;
          if (l2_req_fulfilled) begin
            if (!counter_done) begin
              decrement_counter = 1'b1;
            end else begin
              clear_selected_dirty_bit = 1'b1;
              clear_selected_valid_bit = 1'b1;
              if (pipe_req_type == CLFLUSH) begin
                pipe_req_fulfilled = 1'b1;
                state_next         = IDLE;
              end else begin
                set_new_l2_block_address = 1'b1;
                reset_counter            = 1'b1;
                state_next               = REFILL;
              end
            end
          end
        end

        REFILL: begin
          load_mode    = 1'b1;
          l2_req_valid = 1'b1;
          l2_req_type  = LOAD;
          if (l2_req_fulfilled) begin
            perform_write = 1'b1;
            if (!counter_done) begin
              decrement_counter = 1'b1;
            end else begin
              // The request re-resolves as a hit from IDLE on the following cycle.
              finish_new_line_install = 1'b1;
              state_next              = IDLE;
            end
          end
        end

        default: state_next = IDLE;
      endcase
    end
  end

  property p_request_held;
    @(posedge clk) disable iff (reset)
      (state != IDLE) |-> (pipe_req_valid && $stable(pipe_req_type));
  endproperty
  a_request_held: assert property (p_request_held);

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - controller driven by a behavioural datapath and stalling L2,
// checked against an architectural memory and line-state reference.
module tb_dcache_controller;
  import dcache_controller_pkg::*;

  localparam int WORDS = 8;
  localparam int SETS  = 32;
  localparam int LIMIT = 400;

  localparam logic [12:0] S_FUL   = 13'h1000;
  localparam logic [12:0] S_PW    = 13'h0100;
  localparam logic [12:0] S_SDIRT = 13'h0080;
  localparam logic [12:0] S_CVAL  = 13'h0020;
  localparam logic [12:0] S_NEWA  = 13'h0008;
  localparam logic [12:0] S_DTAG  = 13'h0004;
  localparam logic [12:0] S_RCNT  = 13'h0002;

  typedef struct {
    logic [31:0]       addr;
    memory_operation_e op;
    logic [31:0]       data;
  } l2_txn_t;

  logic clk = 1'b0;
  logic reset;
  logic pipe_req_valid;
  memory_operation_e pipe_req_type;
  logic pipe_req_fulfilled;
  logic l2_req_valid;
  memory_operation_e l2_req_type;
  logic l2_req_fulfilled;
  logic valid_block_match, valid_dirty_bit, counter_done;
  logic flush_mode, load_mode, perform_write;
  logic set_selected_dirty_bit, clear_selected_dirty_bit, clear_selected_valid_bit;
  logic finish_new_line_install, set_new_l2_block_address, use_dirty_tag_for_l2_block_address;
  logic reset_counter, decrement_counter;

  logic [31:0] req_addr, req_wdata;
  int checks = 0;
  int errors = 0;
  int min_stall = 0;
  int max_stall = 0;
  int stall_cnt;
  int stall_total;
  logic [12:0] strobes, first_strobes;
  l2_txn_t l2_log[$];

  logic        dp_valid [SETS];
  logic        dp_dirty [SETS];
  logic [21:0] dp_tag   [SETS];
  logic [31:0] dp_data  [SETS][WORDS];
  logic [21:0] dp_l2_tag;
  logic [2:0]  dp_counter;
  logic [4:0]  req_idx;
  logic [21:0] req_tag;
  logic [2:0]  req_word;
  logic [31:0] l2_addr;

  logic [31:0] l2_mem  [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic        ref_valid [SETS];
  logic        ref_dirty [SETS];
  logic [21:0] ref_tag   [SETS];

  always #5 clk = ~clk;

  dcache_controller #(.LINE_SIZE(32), .CACHE_SIZE(1024), .XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .pipe_req_valid(pipe_req_valid), .pipe_req_type(pipe_req_type),
    .pipe_req_fulfilled(pipe_req_fulfilled),
    .l2_req_valid(l2_req_valid), .l2_req_type(l2_req_type), .l2_req_fulfilled(l2_req_fulfilled),
    .valid_block_match(valid_block_match), .valid_dirty_bit(valid_dirty_bit),
    .counter_done(counter_done), .flush_mode(flush_mode), .load_mode(load_mode),
    .perform_write(perform_write), .set_selected_dirty_bit(set_selected_dirty_bit),
    .clear_selected_dirty_bit(clear_selected_dirty_bit),
    .clear_selected_valid_bit(clear_selected_valid_bit),
    .finish_new_line_install(finish_new_line_install),
    .set_new_l2_block_address(set_new_l2_block_address),
    .use_dirty_tag_for_l2_block_address(use_dirty_tag_for_l2_block_address),
    .reset_counter(reset_counter), .decrement_counter(decrement_counter)
  );

  assign strobes = {pipe_req_fulfilled, l2_req_valid, flush_mode, load_mode, perform_write,
                    set_selected_dirty_bit, clear_selected_dirty_bit, clear_selected_valid_bit,
                    finish_new_line_install, set_new_l2_block_address,
                    use_dirty_tag_for_l2_block_address, reset_counter, decrement_counter};

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] l2_read(input logic [31:0] a);
    return l2_mem.exists(a) ? l2_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Datapath status as seen for the current request address.
  always_comb begin
    req_idx           = req_addr[9:5];
    req_tag           = req_addr[31:10];
    req_word          = req_addr[4:2];
    valid_block_match = dp_valid[req_idx] && (dp_tag[req_idx] == req_tag);
    valid_dirty_bit   = dp_valid[req_idx] && dp_dirty[req_idx];
    counter_done      = (dp_counter == 3'd0);
    l2_addr           = {dp_l2_tag, req_idx, dp_counter, 2'b00};
    l2_req_fulfilled  = l2_req_valid && (stall_cnt == 0);
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        dp_valid[s] <= 1'b0;
        dp_dirty[s] <= 1'b0;
      end
      dp_counter <= '1;
      stall_cnt  <= 0;
    end else begin
      if (perform_write) begin
        if (load_mode) dp_data[req_idx][dp_counter] <= l2_read(l2_addr);
        else dp_data[req_idx][req_word] <= req_wdata;
      end
      if (set_selected_dirty_bit) dp_dirty[req_idx] <= 1'b1;
      if (clear_selected_dirty_bit) dp_dirty[req_idx] <= 1'b0;
      if (clear_selected_valid_bit) dp_valid[req_idx] <= 1'b0;
      if (finish_new_line_install) begin
        dp_valid[req_idx] <= 1'b1;
        dp_tag[req_idx]   <= dp_l2_tag;
      end
      if (set_new_l2_block_address)
        dp_l2_tag <= use_dirty_tag_for_l2_block_address ? dp_tag[req_idx] : req_tag;
      if (reset_counter) dp_counter <= '1;
      else if (decrement_counter) dp_counter <= dp_counter - 3'd1;
      if (l2_req_valid) begin
        if (l2_req_fulfilled) stall_cnt <= int'($urandom_range(max_stall, min_stall));
        else stall_cnt <= stall_cnt - 1;
      end
    end
  end

  // L2 side monitor: logs completed words, commits writebacks, polices stall cycles.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if ({strobes, l2_req_type} !== 15'd0) begin
        errors++;
        $display("FAIL reset_outputs got %b type %0d want all zero", strobes, l2_req_type);
      end
    end else if (l2_req_valid) begin
      if (l2_req_fulfilled) begin
        l2_log.push_back('{addr: l2_addr, op: l2_req_type, data: dp_data[req_idx][dp_counter]});
        if (l2_req_type == STORE) l2_mem[l2_addr] = dp_data[req_idx][dp_counter];
      end else begin
        stall_total++;
        checks++;
        if ({perform_write, decrement_counter, reset_counter, finish_new_line_install,
             pipe_req_fulfilled, clear_selected_dirty_bit, set_new_l2_block_address} !== 7'd0) begin
          errors++;
          $display("FAIL stall_strobes got %b want no strobes while L2 stalls", strobes);
        end
      end
    end
  end

  task automatic ref_resync();
    for (int s = 0; s < SETS; s++) begin
      ref_valid[s] = 1'b0;
      ref_dirty[s] = 1'b0;
    end
    ref_mem = l2_mem;
  endtask

  task automatic do_req(input memory_operation_e op, input logic [31:0] addr,
                        input logic [31:0] wd, input string name);
    logic [4:0]  idx;
    logic [21:0] tag;
    logic        hit, evict, refill, done, bad;
    logic [31:0] rd, old_base, new_base;
    l2_txn_t     exp_q[$];
    int          cyc, exp_lat, bad_i;
    idx      = addr[9:5];
    tag      = addr[31:10];
    hit      = ref_valid[idx] && (ref_tag[idx] == tag);
    evict    = (op == CLFLUSH) ? (hit && ref_dirty[idx]) : (!hit && ref_valid[idx] && ref_dirty[idx]);
    refill   = (op != CLFLUSH) && !hit;
    old_base = {ref_tag[idx], idx, 5'd0};
    new_base = {tag, idx, 5'd0};
    if (evict)
      for (int w = WORDS - 1; w >= 0; w--)
        exp_q.push_back('{addr: old_base + 32'(w * 4), op: STORE, data: ref_read(old_base + 32'(w * 4))});
    if (refill)
      for (int w = WORDS - 1; w >= 0; w--)
        exp_q.push_back('{addr: new_base + 32'(w * 4), op: LOAD, data: 32'd0});

    l2_log.delete();
    stall_total = 0;
    @(posedge clk); #1;
    pipe_req_type  = op;
    req_addr       = addr;
    req_wdata      = wd;
    pipe_req_valid = 1'b1;
    cyc  = 0;
    done = 1'b0;
    rd   = '0;
    while (!done && cyc < LIMIT) begin
      @(negedge clk);
      if (cyc == 0) first_strobes = strobes;
      if (pipe_req_fulfilled) begin
        done = 1'b1;
        rd   = dp_data[idx][addr[4:2]];
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end

    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout got no fulfilled within %0d cycles want fulfilled", name, LIMIT);
      reset = 1'b1;
      @(posedge clk); #1;
      pipe_req_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      ref_resync();
      return;
    end
    @(posedge clk); #1;
    pipe_req_valid = 1'b0;

    if (op == CLFLUSH) exp_lat = evict ? WORDS + stall_total : 0;
    else if (hit) exp_lat = 0;
    else exp_lat = (evict ? WORDS : 0) + WORDS + 1 + stall_total;
    checks++;
    if (cyc != exp_lat) begin
      errors++;
      $display("FAIL %s_latency got %0d want %0d", name, cyc, exp_lat);
    end

    checks++;
    bad   = (l2_log.size() != exp_q.size());
    bad_i = -1;
    for (int i = 0; i < exp_q.size() && !bad; i++) begin
      if (l2_log[i].addr !== exp_q[i].addr || l2_log[i].op !== exp_q[i].op ||
          (exp_q[i].op == STORE && l2_log[i].data !== exp_q[i].data)) begin
        bad   = 1'b1;
        bad_i = i;
      end
    end
    if (bad) begin
      errors++;
      if (bad_i >= 0)
        $display("FAIL %s_l2_word %0d got addr %h op %0d data %h want addr %h op %0d data %h", name, bad_i,
                 l2_log[bad_i].addr, l2_log[bad_i].op, l2_log[bad_i].data,
                 exp_q[bad_i].addr, exp_q[bad_i].op, exp_q[bad_i].data);
      else
        $display("FAIL %s_l2_count got %0d words want %0d", name, l2_log.size(), exp_q.size());
    end

    if (op == LOAD) begin
      checks++;
      if (rd !== ref_read(addr)) begin
        errors++;
        $display("FAIL %s_load_data got %h want %h", name, rd, ref_read(addr));
      end
    end

    case (op)
      LOAD: begin
        if (!hit) ref_dirty[idx] = 1'b0;
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = tag;
      end
      STORE: begin
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = tag;
        ref_dirty[idx] = 1'b1;
        ref_mem[addr]  = wd;
      end
      default: begin
        if (hit) begin
          ref_valid[idx] = 1'b0;
          ref_dirty[idx] = 1'b0;
        end
      end
    endcase
  endtask

  task automatic check_first(input logic [12:0] want, input string name);
    checks++;
    if (first_strobes !== want) begin
      errors++;
      $display("FAIL %s_first_cycle got %b want %b", name, first_strobes, want);
    end
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    pipe_req_valid = 1'b1;
    pipe_req_type  = LOAD;
    req_addr       = 32'h40;
    req_wdata      = '0;
    repeat (3) @(posedge clk);
    #1;
    pipe_req_valid = 1'b0;
    reset          = 1'b0;
    ref_resync();
    @(negedge clk);
    checks++;
    if ({strobes, l2_req_type} !== 15'd0) begin
      errors++;
      $display("FAIL idle_no_request got %b want all zero", strobes);
    end
  endtask

  task automatic test_cold_load();
    do_req(LOAD, 32'h40, '0, "cold_load");
    check_first(S_NEWA | S_RCNT | S_CVAL, "cold_load");
  endtask

  task automatic test_store_hit();
    do_req(STORE, 32'h44, 32'hDEAD_BEEF, "store_hit");
    check_first(S_FUL | S_PW | S_SDIRT, "store_hit");
    do_req(LOAD, 32'h44, '0, "load_after_store");
    check_first(S_FUL, "load_hit");
  endtask

  task automatic test_dirty_conflict();
    do_req(LOAD, 32'h444, '0, "dirty_conflict");
    check_first(S_NEWA | S_DTAG | S_RCNT, "dirty_conflict");
  endtask

  task automatic test_clflush();
    do_req(STORE, 32'h44, 32'h1234_5678, "store_miss_clean");
    do_req(CLFLUSH, 32'h44, '0, "clflush_dirty");
    do_req(CLFLUSH, 32'h44, '0, "clflush_miss");
    check_first(S_FUL, "clflush_miss");
    do_req(LOAD, 32'h44, '0, "load_after_flush");
    do_req(CLFLUSH, 32'h44, '0, "clflush_clean");
    check_first(S_FUL | S_CVAL, "clflush_clean");
  endtask

  task automatic test_reset_mid_refill();
    int words = 0;
    int cyc   = 0;
    @(posedge clk); #1;
    pipe_req_type  = LOAD;
    req_addr       = 32'h1044;
    pipe_req_valid = 1'b1;
    while (words < 4 && cyc < LIMIT) begin
      @(negedge clk);
      if (l2_req_valid && l2_req_fulfilled && l2_req_type == LOAD) words++;
      cyc++;
    end
    checks++;
    if (words != 4) begin
      errors++;
      $display("FAIL mid_refill_words got %0d want 4", words);
    end
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    pipe_req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (strobes !== 13'd0) begin
      errors++;
      $display("FAIL after_reset_idle got %b want all zero", strobes);
    end
    ref_resync();
    do_req(LOAD, 32'h1044, '0, "load_after_reset");
  endtask

  task automatic test_stalls();
    min_stall = 3;
    max_stall = 3;
    do_req(LOAD, 32'h2080, '0, "stall_warmup");
    do_req(LOAD, 32'h2480, '0, "stall_refill");
    checks++;
    if (stall_total != 3 * WORDS) begin
      errors++;
      $display("FAIL stall_total got %0d want %0d", stall_total, 3 * WORDS);
    end
    min_stall = 0;
    max_stall = 0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, d;
    for (int i = 0; i < 2 * WORDS; i++) begin
      @(posedge clk); #1;
      a              = 32'h2480 + 32'((i % WORDS) * 4);
      d              = $urandom;
      pipe_req_type  = (i < WORDS) ? STORE : LOAD;
      req_addr       = a;
      req_wdata      = d;
      pipe_req_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (pipe_req_fulfilled !== 1'b1 || (i >= WORDS && dp_data[4][i % WORDS] !== ref_read(a))) begin
        errors++;
        $display("FAIL back_to_back_%0d got ful %b data %h want ful 1 data %h", i,
                 pipe_req_fulfilled, dp_data[4][i % WORDS], ref_read(a));
      end
      if (i < WORDS) begin
        ref_mem[a]   = d;
        ref_dirty[4] = 1'b1;
      end
    end
    @(posedge clk); #1;
    pipe_req_valid = 1'b0;
  endtask

  task automatic test_random();
    memory_operation_e op;
    int sel;
    max_stall = 3;
    for (int i = 0; i < 80; i++) begin
      sel = int'($urandom_range(9, 0));
      op  = (sel < 4) ? LOAD : (sel < 8) ? STORE : CLFLUSH;
      do_req(op, {22'($urandom_range(3, 0)), 5'($urandom_range(3, 0)), 3'($urandom_range(7, 0)), 2'b00},
             $urandom, "random");
    end
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_store_hit();
    test_dirty_conflict();
    test_clflush();
    test_reset_mid_refill();
    test_stalls();
    test_back_to_back();
    test_random();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
